stim_burst_sequencer: RTL and testbench
=======================================

Name: stim_burst_sequencer

Overview:
- Upstream stimulus stage for the inline-assertion test top.
- Accepts burst commands over a valid/ready handshake.
- Drives the top's `I` input with a paced train of single-bit pulses, and its 2-bit `arr` input with an arm/fire sequence.
- Output timing is constructed so the downstream properties `I |-> ##1 O` and `arr[0] |-> ##1 arr[1]` hold by design.

Parameters:
- CNT_WIDTH, 8, width of the burst-length field and internal pulse counter.
- GAP, 1, number of idle (low) cycles inserted between consecutive pulses on O; 0 means pulses are back-to-back.

Ports:
- CLK  input  1  rising-edge clock.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_len  input  CNT_WIDTH  number of pulses to emit; sampled on handshake.
- O  output  1  pulse train; drives downstream `I`.
- arr_o  output  2  arm/fire sequence; drives downstream `arr`.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset (ASYNCRESETN=0, asynchronous):
  - State goes to IDLE; counters clear.
  - O=0, arr_o=2'b00, busy=0, done=0.
  - cmd_ready=0 while reset is asserted; cmd_ready=1 in the first cycle after release.
- O, arr_o, busy and done are registered (Moore). cmd_ready is combinational and equals (state==IDLE).
- Handshake: a command is accepted at the rising edge where cmd_valid && cmd_ready. cmd_valid while cmd_ready=0 is ignored; the command is neither queued nor dropped-with-error. cmd_len is latched only at acceptance.
- States: IDLE, ARM, PULSE, GAP, DONE. Cycle 0 denotes the acceptance edge.
- IDLE:
  - cmd_len!=0 -> ARM.
  - cmd_len==0 -> DONE directly. No arr_o activity and no pulses.
- ARM (cycle 1):
  - arr_o=2'b01, busy=1, O=0.
  - Remaining counter is loaded with cmd_len.
  - Next state is PULSE.
- PULSE:
  - O=1 for exactly one cycle; remaining count decrements.
  - arr_o=2'b10 in the first PULSE cycle only, and 2'b00 afterwards.
  - If the count reaches 0 -> DONE.
  - Otherwise -> GAP when GAP>0, or stay in PULSE when GAP==0 (O held high continuously).
- GAP: O=0 for exactly GAP cycles, then -> PULSE.
- DONE: done=1 and busy=1 for one cycle, O=0, arr_o=2'b00; then -> IDLE.
- Pulse timing: pulse k (1-based) occurs at cycle 2+(k-1)*(GAP+1). done is asserted one cycle after the last pulse. cmd_ready returns the following cycle.
- Invariants:
  - arr_o==2'b11 never occurs.
  - arr_o[1] is asserted only in the cycle immediately after arr_o[0].
  - arr_o[0] is asserted exactly once per nonzero command.
- Width: cmd_len up to 2^CNT_WIDTH-1 (255 at default) is legal. The counter never wraps; it decrements only from a nonzero value.
- Reset mid-burst: all outputs go to 0 immediately (asynchronously) and the latched count is discarded. No done is issued for the aborted command.

Test Plan:
- Reset release, then cmd_valid=1 with cmd_len=3, GAP=1, accepted at cycle 0:
  - arr_o=01 at cycle 1, arr_o=10 at cycle 2.
  - O high at cycles 2, 4, 6.
  - done=1 at cycle 7; cmd_ready=1 at cycle 8.
  - busy=1 for cycles 1–7.
- GAP=0 build, cmd_len=4: O high for cycles 2–5 contiguous, done at cycle 6; downstream `I |-> ##1 O` passes.
- cmd_len=0: done=1 at cycle 1; O and arr_o stay 0 throughout; cmd_ready=1 at cycle 2.
- Back-to-back commands: cmd_valid held high with cmd_len=2 then cmd_len=5:
  - The second command is accepted only in the cycle cmd_ready returns.
  - It yields exactly 5 pulses; no pulses are lost or merged between the two commands.
- ASYNCRESETN pulled low between clock edges during the 2nd pulse of a cmd_len=10 burst:
  - O, arr_o and busy go to 0 immediately; no done strobe.
  - After release, cmd_ready=1 and a fresh cmd_len=1 command completes normally.
- cmd_len=255 (max): exactly 255 O pulses; the counter does not wrap; single done. The arr assertion is checked on every cycle.

Source files
------------

// File: rtl/stim_burst_sequencer_if.sv
// Command channel for the burst sequencer: valid/ready handshake plus burst length.
interface stim_burst_sequencer_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CNT_WIDTH-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_len, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_len, output cmd_ready);
endinterface

// File: rtl/stim_burst_sequencer.sv
// Burst stimulus sequencer: on each accepted command emits an arm/fire pair on
// arr_o and a paced train of cmd_len single-cycle pulses on O, then a done strobe.
// All pin outputs except cmd_ready are registered from the next state.
module stim_burst_sequencer #(
    parameter int CNT_WIDTH = 8,
    parameter int GAP       = 1
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESETN,
    stim_burst_sequencer_if.slave         cmd,
    output logic                          O,
    output logic [1:0]                    arr_o,
    output logic                          busy,
    output logic                          done
);
    // Gap counter only needs to reach GAP-1; keep at least one bit for GAP<2.
    localparam int           GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] remain;
    logic [GW-1:0]        gap_cnt;
    logic                 accept;
    logic                 o_n;
    logic [1:0]           arr_n;
    logic                 busy_n;
    logic                 done_n;

    // Ready is held low while reset is applied so nothing can be accepted then.
    assign cmd.cmd_ready = ASYNCRESETN && (state == S_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // State register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) state <= S_IDLE;
        else              state <= state_n;
    end

    // Next-state logic and the values the output registers take next cycle.
    always_comb begin
        state_n = state;
        o_n     = 1'b0;
        arr_n   = 2'b00;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_n = (cmd.cmd_len != '0) ? S_ARM : S_DONE;
            S_ARM:   state_n = S_PULSE;
            S_PULSE: begin
                // remain still holds the pre-decrement count in this cycle.
                if (remain <= CNT_WIDTH'(1)) state_n = S_DONE;
                else if (GAP > 0)            state_n = S_GAP;
                else                         state_n = S_PULSE;
            end
            S_GAP:   if (gap_cnt == GAP_LAST) state_n = S_PULSE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        o_n    = (state_n == S_PULSE);
        // Fire follows arm by exactly one cycle; ARM always leads into PULSE.
        if (state_n == S_ARM)  arr_n = 2'b01;
        else if (state == S_ARM) arr_n = 2'b10;
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    // Registered Moore outputs.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            O     <= 1'b0;
            arr_o <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            O     <= o_n;
            arr_o <= arr_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Burst length latch, remaining-pulse counter and gap pacing counter.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            len_q   <= '0;
            remain  <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) len_q <= cmd.cmd_len;
            if (state == S_ARM) remain <= len_q;
            else if (state == S_PULSE && remain != '0) remain <= remain - 1'b1;
            if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                gap_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_stim_burst_sequencer.sv
// Bench for stim_burst_sequencer: a GAP=1 and a GAP=0 instance, cycle-exact
// scenario tasks plus per-instance monitors that score pulse/arm counts per done.
module tb_stim_burst_sequencer;
    logic       CLK;
    logic       ASYNCRESETN;
    logic       O1, O0, busy1, busy0, done1, done0;
    logic [1:0] arr1, arr0;

    int checks   = 0;
    int failures = 0;

    int q1[$];
    int q0[$];

    stim_burst_sequencer_if #(.CNT_WIDTH(8)) if1 ();
    stim_burst_sequencer_if #(.CNT_WIDTH(8)) if0 ();

    stim_burst_sequencer #(.CNT_WIDTH(8), .GAP(1)) dut1 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .cmd(if1),
        .O(O1), .arr_o(arr1), .busy(busy1), .done(done1)
    );
    stim_burst_sequencer #(.CNT_WIDTH(8), .GAP(0)) dut0 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .cmd(if0),
        .O(O0), .arr_o(arr0), .busy(busy0), .done(done0)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Scoreboard monitor for the GAP=1 instance.
    int         pc1 = 0, ac1 = 0;
    logic [1:0] prev1 = 2'b00;
    always @(negedge CLK) begin
        if (!ASYNCRESETN) begin
            pc1 = 0; ac1 = 0; prev1 = 2'b00;
        end else begin
            checks++;
            if (arr1 === 2'b11 || (arr1[1] === 1'b1 && prev1[0] !== 1'b1)) begin
                failures++;
                $display("FAIL arr_seq1: arr=%b prev=%b", arr1, prev1);
            end
            if (O1 === 1'b1) pc1++;
            if (arr1[0] === 1'b1) ac1++;
            if (done1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL done1_unexpected: done with no command outstanding");
                end else begin
                    int e;
                    e = q1.pop_front();
                    if (pc1 !== e || ac1 !== ((e != 0) ? 1 : 0)) begin
                        failures++;
                        $display("FAIL pulses1: got pulses=%0d arms=%0d expected pulses=%0d arms=%0d",
                                 pc1, ac1, e, (e != 0) ? 1 : 0);
                    end
                end
                pc1 = 0; ac1 = 0;
            end
            prev1 = arr1;
        end
    end

    // Scoreboard monitor for the GAP=0 instance.
    int         pc0 = 0, ac0 = 0;
    logic [1:0] prev0 = 2'b00;
    always @(negedge CLK) begin
        if (!ASYNCRESETN) begin
            pc0 = 0; ac0 = 0; prev0 = 2'b00;
        end else begin
            checks++;
            if (arr0 === 2'b11 || (arr0[1] === 1'b1 && prev0[0] !== 1'b1)) begin
                failures++;
                $display("FAIL arr_seq0: arr=%b prev=%b", arr0, prev0);
            end
            if (O0 === 1'b1) pc0++;
            if (arr0[0] === 1'b1) ac0++;
            if (done0 === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL done0_unexpected: done with no command outstanding");
                end else begin
                    int e;
                    e = q0.pop_front();
                    if (pc0 !== e || ac0 !== ((e != 0) ? 1 : 0)) begin
                        failures++;
                        $display("FAIL pulses0: got pulses=%0d arms=%0d expected pulses=%0d arms=%0d",
                                 pc0, ac0, e, (e != 0) ? 1 : 0);
                    end
                end
                pc0 = 0; ac0 = 0;
            end
            prev0 = arr0;
        end
    end

    // Present a command and return at the posedge that accepts it.
    // waited = extra negedges spent waiting for cmd_ready.
    task automatic accept(input int sel, input int len, output int waited);
        int n = 0;
        @(negedge CLK);
        if (sel == 1) begin if1.cmd_valid = 1; if1.cmd_len = 8'(len); end
        else          begin if0.cmd_valid = 1; if0.cmd_len = 8'(len); end
        while (((sel == 1) ? if1.cmd_ready : if0.cmd_ready) !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        waited = n;
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL accept_timeout: sel=%0d len=%0d", sel, len);
        end else if (sel == 1) q1.push_back(len);
        else                   q0.push_back(len);
        @(posedge CLK);
    endtask

    task automatic wait_idle(input int sel, input int limit);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (((sel == 1) ? (if1.cmd_ready !== 1'b1 || busy1 !== 1'b0)
                               : (if0.cmd_ready !== 1'b1 || busy0 !== 1'b0)) && n < limit);
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL idle_timeout: sel=%0d waited=%0d", sel, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({O1, arr1, busy1, done1, if1.cmd_ready, O0, arr0, busy0, done0, if0.cmd_ready} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {O1, arr1, busy1, done1, if1.cmd_ready, O0, arr0, busy0, done0, if0.cmd_ready});
        end
        ASYNCRESETN = 1;
        #1;
        checks++;
        if ({if1.cmd_ready, if0.cmd_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 11", {if1.cmd_ready, if0.cmd_ready});
        end
    endtask

    // GAP=1, len=3: arm@1, fire@2, pulses 2/4/6, done@7, ready@8.
    task automatic test_basic();
        int w;
        logic [5:0] exp_v;
        accept(1, 3, w);
        #1 if1.cmd_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            exp_v[5]   = (k == 2 || k == 4 || k == 6);
            exp_v[4:3] = (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b00;
            exp_v[2]   = (k >= 1 && k <= 7);
            exp_v[1]   = (k == 7);
            exp_v[0]   = (k == 8);
            checks++;
            if ({O1, arr1, busy1, done1, if1.cmd_ready} !== exp_v) begin
                failures++;
                $display("FAIL basic_cycle%0d: got O/arr/busy/done/rdy=%b expected %b",
                         k, {O1, arr1, busy1, done1, if1.cmd_ready}, exp_v);
            end
        end
    endtask

    // GAP=0, len=4: O continuous for cycles 2..5, done@6, ready@7.
    task automatic test_gap0();
        int w;
        logic [5:0] exp_v;
        accept(0, 4, w);
        #1 if0.cmd_valid = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            exp_v[5]   = (k >= 2 && k <= 5);
            exp_v[4:3] = (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b00;
            exp_v[2]   = (k >= 1 && k <= 6);
            exp_v[1]   = (k == 6);
            exp_v[0]   = (k == 7);
            checks++;
            if ({O0, arr0, busy0, done0, if0.cmd_ready} !== exp_v) begin
                failures++;
                $display("FAIL gap0_cycle%0d: got O/arr/busy/done/rdy=%b expected %b",
                         k, {O0, arr0, busy0, done0, if0.cmd_ready}, exp_v);
            end
        end
    endtask

    // len=0: done@1 with no arm/pulse activity, ready@2.
    task automatic test_zero_len();
        int w;
        logic [5:0] exp_v;
        accept(1, 0, w);
        #1 if1.cmd_valid = 0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            exp_v = (k == 1) ? 6'b000110 : 6'b000001;
            checks++;
            if ({O1, arr1, busy1, done1, if1.cmd_ready} !== exp_v) begin
                failures++;
                $display("FAIL zero_len_cycle%0d: got O/arr/busy/done/rdy=%b expected %b",
                         k, {O1, arr1, busy1, done1, if1.cmd_ready}, exp_v);
            end
        end
    endtask

    // cmd_valid held high across two commands; the second waits for ready.
    task automatic test_back_to_back();
        int w;
        accept(1, 2, w);
        accept(1, 5, w);
        #1 if1.cmd_valid = 0;
        checks++;
        if (w !== 5) begin
            failures++;
            $display("FAIL b2b_accept_wait: got %0d cycles expected 5", w);
        end
        wait_idle(1, 100);
    endtask

    // Async reset during the 2nd pulse of a len=10 burst, then a fresh len=1 command.
    task automatic test_reset_mid_burst();
        int w;
        accept(1, 10, w);
        #1 if1.cmd_valid = 0;
        repeat (4) @(negedge CLK);
        checks++;
        if (O1 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pulse2: got O=%b expected 1", O1);
        end
        #2 ASYNCRESETN = 0;
        #1;
        checks++;
        if ({O1, arr1, busy1, done1, if1.cmd_ready} !== 5'b00000) begin
            failures++;
            $display("FAIL midrst_async_clear: got %b expected 00000",
                     {O1, arr1, busy1, done1, if1.cmd_ready});
        end
        q1.delete();
        repeat (2) @(negedge CLK);
        ASYNCRESETN = 1;
        #1;
        checks++;
        if (if1.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready: got %b expected 1", if1.cmd_ready);
        end
        accept(1, 1, w);
        #1 if1.cmd_valid = 0;
        wait_idle(1, 50);
    endtask

    task automatic test_max_len();
        int w;
        accept(1, 255, w);
        #1 if1.cmd_valid = 0;
        wait_idle(1, 1000);
    endtask

    initial begin
        ASYNCRESETN   = 0;
        if1.cmd_valid = 0; if1.cmd_len = '0;
        if0.cmd_valid = 0; if0.cmd_len = '0;
        test_reset();
        test_basic();
        test_gap0();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_burst();
        test_max_len();
        repeat (3) @(negedge CLK);
        checks++;
        if (q1.size() !== 0 || q0.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending q1=%0d q0=%0d expected 0", q1.size(), q0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
